// File: rtl/width_trim_destruct_if.sv
// -----------------------------------------------------------------------------
// width_trim_destruct_if
// Bundles the wide write side and the narrow read side of the width splitter.
//
// Signals:
//   wr_data  [DSIZE*NSIZE] wide word, lane k = bits [k*DSIZE +: DSIZE]
//   wr_vld                 wide word valid
//   wr_ready               splitter can take a word this cycle
//   wr_last                word closes the packet
//   wr_cnt   [CSIZE]       valid lanes in a last word (0 = all NSIZE lanes)
//   rd_data  [DSIZE]       current narrow lane
//   rd_vld                 narrow lane valid
//   rd_ready               consumer takes the lane
//   rd_last                lane is the final valid lane of the packet
//
// Modports:
//   slave  - the splitter itself (consumes wr_*, produces rd_*)
//   master - the surrounding environment (produces wr_*, consumes rd_*)
// -----------------------------------------------------------------------------
interface width_trim_destruct_if #(
    parameter int DSIZE = 8,
    parameter int NSIZE = 4
);
    localparam int CSIZE = $clog2(NSIZE);
    localparam int WSIZE = DSIZE * NSIZE;

    logic [WSIZE-1:0] wr_data;
    logic             wr_vld;
    logic             wr_ready;
    logic             wr_last;
    logic [CSIZE-1:0] wr_cnt;
    logic [DSIZE-1:0] rd_data;
    logic             rd_vld;
    logic             rd_ready;
    logic             rd_last;

    modport slave (
        input  wr_data,
        input  wr_vld,
        output wr_ready,
        input  wr_last,
        input  wr_cnt,
        output rd_data,
        output rd_vld,
        input  rd_ready,
        output rd_last
    );

    modport master (
        output wr_data,
        output wr_vld,
        input  wr_ready,
        output wr_last,
        output wr_cnt,
        input  rd_data,
        input  rd_vld,
        output rd_ready,
        input  rd_last
    );
endinterface

// File: rtl/width_trim_destruct.sv
// -----------------------------------------------------------------------------
// width_trim_destruct
// Wide-to-narrow stream splitter. Each accepted DSIZE*NSIZE-bit word is
// replayed as NSIZE DSIZE-bit lanes, lowest lane first. On the last word of
// a packet only the first wr_cnt lanes are replayed (wr_cnt = 0 means all of
// them); the remaining pad lanes are dropped without ever being presented.
//
// Ports:
//   clock  - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - width_trim_destruct_if.slave (wr_* in, rd_* out, see interface)
//
// The read side (rd_data, rd_vld, rd_last) comes straight from flops. Only
// wr_ready is combinational: it looks at rd_ready so that a new word can be
// loaded in the same cycle the last lane of the previous word leaves.
// -----------------------------------------------------------------------------
module width_trim_destruct #(
    parameter int DSIZE = 8,
    parameter int NSIZE = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    width_trim_destruct_if.slave  bus
);
    localparam int CSIZE = $clog2(NSIZE);
    localparam int WSIZE = DSIZE * NSIZE;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CSIZE-1:0] lane_r;
    logic [CSIZE-1:0] end_lane_r;
    logic             held_last_r;
    logic [WSIZE-1:0] hold_r;
    logic [DSIZE-1:0] rd_data_r;
    logic             rd_last_r;

    logic             full_s;
    logic             at_end_s;
    logic             wr_ready_s;
    logic             wr_acc_s;
    logic             rd_xfer_s;
    logic             word_done_s;
    logic [CSIZE-1:0] end_lane_in_s;
    logic [CSIZE-1:0] lane_next_s;

    // Pick lane idx out of a wide word.
    function automatic logic [DSIZE-1:0] lane_sel(
        input logic [WSIZE-1:0] word,
        input logic [CSIZE-1:0] idx
    );
        lane_sel = DSIZE'(word >> (32'(idx) * DSIZE));
    endfunction

    // Handshake decode and index of the last lane an incoming word will emit.
    always_comb begin
        full_s      = (state_r == SEND);
        at_end_s    = (lane_r == end_lane_r);
        lane_next_s = lane_r + CSIZE'(1);
        // wr_ready stays low through reset so nothing is taken while flops clear.
        if (!rst_n) begin
            wr_ready_s = 1'b0;
        end else if (!full_s) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = bus.rd_ready && at_end_s;
        end
        wr_acc_s    = bus.wr_vld && wr_ready_s;
        rd_xfer_s   = full_s && bus.rd_ready;
        word_done_s = rd_xfer_s && at_end_s;
        // wr_cnt only trims a last word; 0 on a last word still means "all lanes".
        if (bus.wr_last && (bus.wr_cnt != {CSIZE{1'b0}})) begin
            end_lane_in_s = bus.wr_cnt - CSIZE'(1);
        end else begin
            end_lane_in_s = CSIZE'(NSIZE - 1);
        end
    end

    // Splitter FSM: word load, lane stepping and registered read-side outputs.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            lane_r      <= {CSIZE{1'b0}};
            end_lane_r  <= {CSIZE{1'b0}};
            held_last_r <= 1'b0;
            hold_r      <= {WSIZE{1'b0}};
            rd_data_r   <= {DSIZE{1'b0}};
            rd_last_r   <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (wr_acc_s) begin
                        state_r     <= SEND;
                        lane_r      <= {CSIZE{1'b0}};
                        end_lane_r  <= end_lane_in_s;
                        held_last_r <= bus.wr_last;
                        hold_r      <= bus.wr_data;
                        rd_data_r   <= bus.wr_data[DSIZE-1:0];
                        rd_last_r   <= bus.wr_last && (end_lane_in_s == {CSIZE{1'b0}});
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                SEND: begin
                    if (wr_acc_s) begin
                        // Last lane leaves while the next word arrives: reload in place.
                        state_r     <= SEND;
                        lane_r      <= {CSIZE{1'b0}};
                        end_lane_r  <= end_lane_in_s;
                        held_last_r <= bus.wr_last;
                        hold_r      <= bus.wr_data;
                        rd_data_r   <= bus.wr_data[DSIZE-1:0];
                        rd_last_r   <= bus.wr_last && (end_lane_in_s == {CSIZE{1'b0}});
                    end else if (word_done_s) begin
                        // Lanes past end_lane are pad and are simply never shown.
                        state_r   <= EMPTY;
                        rd_last_r <= 1'b0;
                    end else if (rd_xfer_s) begin
                        lane_r    <= lane_next_s;
                        rd_data_r <= lane_sel(hold_r, lane_next_s);
                        rd_last_r <= held_last_r && (lane_next_s == end_lane_r);
                    end else begin
                        // Consumer stalled: everything holds.
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r   <= EMPTY;
                    rd_last_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready = wr_ready_s;
    assign bus.rd_vld   = full_s;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_last  = rd_last_r;

endmodule

// File: tb/tb_width_trim_destruct.sv
// -----------------------------------------------------------------------------
// tb_width_trim_destruct
// Scenario tasks drive wide words; each accepted word pushes its expected
// lanes (data + last flag) onto a queue. A monitor pops and compares on every
// lane transfer and also checks that a stalled lane stays put.
// -----------------------------------------------------------------------------
module tb_width_trim_destruct;
    localparam int DSIZE = 8;
    localparam int NSIZE = 4;
    localparam int CSIZE = $clog2(NSIZE);

    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    logic [DSIZE:0] exp_q[$];

    width_trim_destruct_if #(.DSIZE(DSIZE), .NSIZE(NSIZE)) bus ();

    width_trim_destruct #(.DSIZE(DSIZE), .NSIZE(NSIZE)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: scoreboard pop on transfer, stability check on stall.
    initial begin
        logic           prev_stall;
        logic [DSIZE-1:0] prev_data;
        logic           prev_last;
        logic [DSIZE:0] exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clock);
            if (rst_n === 1'b1 && prev_stall) begin
                checks++;
                if (bus.rd_vld !== 1'b1 || bus.rd_data !== prev_data || bus.rd_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got vld=%b data=%h last=%b, need vld=1 data=%h last=%b",
                             bus.rd_vld, bus.rd_data, bus.rd_last, prev_data, prev_last);
                end
            end
            if (rst_n === 1'b1 && bus.rd_vld === 1'b1 && bus.rd_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_lane: got data=%h last=%b, need no lane", bus.rd_data, bus.rd_last);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.rd_data !== exp[DSIZE-1:0] || bus.rd_last !== exp[DSIZE]) begin
                        errors++;
                        $display("FAIL lane: got data=%h last=%b, need data=%h last=%b",
                                 bus.rd_data, bus.rd_last, exp[DSIZE-1:0], exp[DSIZE]);
                    end
                end
            end
            prev_stall = (rst_n === 1'b1) && (bus.rd_vld === 1'b1) && (bus.rd_ready === 1'b0);
            prev_data  = bus.rd_data;
            prev_last  = bus.rd_last;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_expected(input logic [DSIZE*NSIZE-1:0] data, input logic last,
                                 input logic [CSIZE-1:0] cnt);
        int n;
        logic [DSIZE*NSIZE-1:0] w;
        w = data;
        n = (last && cnt != 0) ? int'(cnt) : NSIZE;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({last && (k == n - 1), w[k*DSIZE +: DSIZE]});
        end
    endtask

    // Present one word, wait (bounded) for acceptance, return just after the accept edge.
    task automatic send_word(input logic [DSIZE*NSIZE-1:0] data, input logic last,
                             input logic [CSIZE-1:0] cnt);
        int t;
        bus.wr_data = data;
        bus.wr_last = last;
        bus.wr_cnt  = cnt;
        bus.wr_vld  = 1'b1;
        t = 0;
        while (bus.wr_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: got wr_ready=%b, need 1 within 50 cycles", bus.wr_ready);
        end else begin
            push_expected(data, last, cnt);
        end
        step();
        bus.wr_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d lanes pending, need 0", name, exp_q.size());
        end
        checks++;
        if (bus.rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got rd_vld=%b, need 0", name, bus.rd_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.rd_vld !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_data !== 8'h00 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got vld=%b last=%b data=%h wr_ready=%b, need 0 0 00 0",
                     bus.rd_vld, bus.rd_last, bus.rd_data, bus.wr_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got wr_ready=%b rd_vld=%b, need 1 0", bus.wr_ready, bus.rd_vld);
        end
    endtask

    task automatic test_full_word();
        bus.rd_ready = 1'b1;
        // wr_cnt must be ignored on a non-last word.
        send_word(32'h44332211, 1'b0, 2'd1);
        checks++;
        if (bus.rd_vld !== 1'b1 || bus.rd_data !== 8'h11 || bus.rd_last !== 1'b0) begin
            errors++;
            $display("FAIL full_word_latency: got vld=%b data=%h last=%b, need 1 11 0",
                     bus.rd_vld, bus.rd_data, bus.rd_last);
        end
        wait_drain("full_word");
    endtask

    task automatic test_trimmed_last();
        bus.rd_ready = 1'b1;
        send_word(32'hDDCCBBAA, 1'b1, 2'd2);
        wait_drain("trimmed_last");
    endtask

    task automatic test_cnt_zero_last();
        bus.rd_ready = 1'b1;
        send_word(32'h87654321, 1'b1, 2'd0);
        wait_drain("cnt_zero_last");
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int sent;
        words[0] = 32'hA3A2A1A0;
        words[1] = 32'hB3B2B1B0;
        words[2] = 32'hC3C2C1C0;
        sent = 0;
        bus.rd_ready = 1'b1;
        bus.wr_last  = 1'b0;
        bus.wr_cnt   = 2'd0;
        bus.wr_data  = words[0];
        bus.wr_vld   = 1'b1;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (bus.wr_ready !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL b2b_wr_ready: cycle %0d got %b, need %b", i, bus.wr_ready, ((i % 4) == 0));
            end
            checks++;
            if (bus.rd_vld !== (i != 0)) begin
                errors++;
                $display("FAIL b2b_rd_vld: cycle %0d got %b, need %b", i, bus.rd_vld, (i != 0));
            end
            if (bus.wr_vld && bus.wr_ready === 1'b1) begin
                push_expected(words[sent], 1'b0, 2'd0);
                sent++;
            end
            step();
            if (sent < 3) begin
                bus.wr_data = words[sent];
            end else begin
                bus.wr_vld = 1'b0;
            end
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_single_lane();
        bus.rd_ready = 1'b1;
        bus.wr_last  = 1'b1;
        bus.wr_cnt   = 2'd1;
        bus.wr_vld   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = {8'hF0, 8'hE0, 8'hD0, 8'(8'h50 + i)};
            checks++;
            if (bus.wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_lane_ready: cycle %0d got %b, need 1", i, bus.wr_ready);
            end else begin
                push_expected(bus.wr_data, 1'b1, 2'd1);
            end
            step();
        end
        bus.wr_vld = 1'b0;
        wait_drain("single_lane");
    endtask

    task automatic test_backpressure();
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.rd_ready = 1'b0;
        send_word(32'h04030201, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) begin
            bus.rd_ready = pat[i];
            step();
        end
        checks++;
        if (exp_q.size() != 0 || bus.rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done: got pending=%0d rd_vld=%b, need 0 0", exp_q.size(), bus.rd_vld);
        end
        bus.rd_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_reset_mid_word();
        bus.rd_ready = 1'b1;
        send_word(32'h44332211, 1'b0, 2'd0);
        step();
        step();
        // Lanes 0x11 and 0x22 have left; 0x33/0x44 must be discarded.
        rst_n = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_wr_ready: got %b, need 0", bus.wr_ready);
        end
        step();
        checks++;
        if (bus.rd_vld !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_out: got vld=%b last=%b data=%h, need 0 0 00",
                     bus.rd_vld, bus.rd_last, bus.rd_data);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_release: got wr_ready=%b, need 1", bus.wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.rd_vld !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: cycle %0d got rd_vld=%b, need 0", i, bus.rd_vld);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.wr_data  = '0;
        bus.wr_vld   = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_cnt   = '0;
        bus.rd_ready = 1'b0;
        test_reset();
        test_full_word();
        test_trimmed_last();
        test_cnt_zero_last();
        test_back_to_back();
        test_single_lane();
        test_backpressure();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
